regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: requester 0 is the ALU writeback and requester 1 is the load/memory writeback.
- Each requester has a 2-entry queue. Round-robin arbitration pops one queued write per cycle and drives registered write_enable, write_address and write_data into the register file.
- Also exports a pending-write mask. Issue logic uses it to detect read-after-write hazards against queued writes.

Parameters:
- W, 16, data width; matches the register file width.
- ZERO_REG_DISCARD, 0, when 1 a write targeting address 0 is accepted and dequeued normally but never asserts write_enable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_asynchronous  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of both queues and the output stage.
- req0_valid  input  1  requester 0 has a write.
- req0_ready  output  1  requester 0 queue can accept.
- req0_address  input  4  requester 0 destination register.
- req0_data  input  W  requester 0 write data.
- req1_valid  input  1  requester 1 has a write.
- req1_ready  output  1  requester 1 queue can accept.
- req1_address  input  4  requester 1 destination register.
- req1_data  input  W  requester 1 write data.
- write_enable  output  1  register file write enable, registered.
- write_address  output  4  register file write address, registered.
- write_data  output  W  register file write data, registered.
- pending_mask  output  16  bit r=1 if any queued or in-flight write targets register r.
- conflict_count  output  8  saturating count of cycles in which both queues were non-empty.

Behaviour:
- Reset (asynchronous, active-high):
  - Queues empty; round-robin pointer = 0 (requester 0 favoured first).
  - write_enable=0, write_address=0, write_data=0, conflict_count=0, pending_mask=0.
  - req0_ready=1 and req1_ready=1 once reset deasserts. Reset mid-transfer discards all queued writes.
- Handshake and queues:
  - A transfer on port k occurs at a rising edge with reqk_valid=1 and reqk_ready=1.
  - reqk_ready = (queue k count < 2). It depends only on the registered count, not on a same-cycle pop, so a full queue never accepts, even while popping.
  - Each queue is strict FIFO. Push and pop in the same cycle on a non-full queue are both honoured.
- Arbitration (each edge, queues as they stood before that edge):
  - Only one queue non-empty: pop its head.
  - Both non-empty: pop the queue selected by the pointer, then set pointer = other queue, and increment conflict_count (saturates at 255).
  - Single-queue grants also set pointer = other queue.
  - Neither non-empty: no pop, pointer unchanged.
- Output stage, registered on the pop edge:
  - write_address and write_data take the popped head.
  - write_enable=1, except when ZERO_REG_DISCARD=1 and the address is 0, in which case write_enable=0.
  - No pop: write_enable=0; write_address and write_data hold their last values.
- Latency:
  - A write accepted at edge t into an empty queue, with no competing entry, shows write_enable=1 during cycle t+1→t+2. The register file captures it at edge t+2.
  - Throughput is one write per cycle sustained.
- pending_mask: combinational OR of one-hot(address) over all valid queue entries, plus write_address when write_enable=1.
- Ordering:
  - Same-port writes always commit in acceptance order.
  - Cross-port writes to the same address commit in grant order. Requesters needing cross-port ordering must use pending_mask.
- flush:
  - At an edge with flush=1, both queues are emptied and write_enable←0.
  - Simultaneous pushes are dropped, and no pop occurs.
  - Pointer and conflict_count are unchanged.
- reset_asynchronous takes priority over flush.

Test Plan:
- Single write: after reset, req0 writes address 5, data 0x1234 at edge 1 → write_enable=1 with address 5 and data 0x1234 during cycle 2→3. pending_mask=0x0020 during cycles 1→3, then 0.
- Contention: both ports push simultaneously every cycle for 4 cycles (req0 addresses 1,2,3,4; req1 addresses 9,10,11,12) → write sequence is 1,9,2,10,3,11,4,12. req0_ready/req1_ready drop when a queue reaches 2 entries. conflict_count reaches the number of both-non-empty cycles, with no lost or duplicated write.
- Backpressure: hold req1_valid=1 continuously while req0 streams → req1_ready=0 whenever count=2. No push is accepted on those edges, and data order per port is preserved.
- Zero register: ZERO_REG_DISCARD=1, req0 writes address 0, data 0xFFFF → entry is dequeued, write_enable stays 0, req0_ready recovers. With ZERO_REG_DISCARD=0 the same stimulus gives write_enable=1 with address 0.
- Flush: both queues full, assert flush for one cycle → next cycle write_enable=0, pending_mask=0, both readys=1. Queued writes never appear.
- Async reset mid-stream: assert reset_asynchronous between edges with 3 writes queued → outputs go to 0 immediately, without waiting for a clock edge. After release, first write enters with the pointer favouring requester 0; conflict_count is 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: two 2-entry writeback queues (ALU, load),
// round-robin grant, registered write port and a pending-write hazard mask.
module regfile_write_arbiter #(
    parameter int W                = 16,
    parameter bit ZERO_REG_DISCARD = 1'b0
) (
    input  logic         clk,
    input  logic         reset_asynchronous,
    input  logic         flush,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_address,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_address,
    input  logic [W-1:0] req1_data,
    output logic         write_enable,
    output logic [3:0]   write_address,
    output logic [W-1:0] write_data,
    output logic [15:0]  pending_mask,
    output logic [7:0]   conflict_count
);

    // Queue storage: entry 0 is always the head.
    logic [3:0]   r_q_addr [2][2];
    logic [W-1:0] r_q_data [2][2];
    logic [1:0]   r_count  [2];
    logic         r_ptr;
    logic [7:0]   r_conflict;
    logic         r_we;
    logic [3:0]   r_waddr;
    logic [W-1:0] r_wdata;

    logic [3:0]   w_in_addr [2];
    logic [W-1:0] w_in_data [2];
    logic [1:0]   w_nonempty;
    logic [1:0]   w_ready;
    logic [1:0]   w_push;
    logic [1:0]   w_pop;
    logic         w_grant1;
    logic [3:0]   w_head_addr;
    logic [W-1:0] w_head_data;
    logic [15:0]  w_mask;

    assign w_in_addr[0] = req0_address;
    assign w_in_addr[1] = req1_address;
    assign w_in_data[0] = req0_data;
    assign w_in_data[1] = req1_data;

    // Ready comes from the registered count only, so a full queue never accepts.
    always_comb begin
        w_nonempty[0] = (r_count[0] != 2'd0);
        w_nonempty[1] = (r_count[1] != 2'd0);
        w_ready[0]    = (r_count[0] < 2'd2);
        w_ready[1]    = (r_count[1] < 2'd2);
        w_grant1      = w_nonempty[1] && (!w_nonempty[0] || r_ptr);
        w_pop[0]      = !flush && w_nonempty[0] && !w_grant1;
        w_pop[1]      = !flush && w_grant1;
        w_push[0]     = !flush && req0_valid && w_ready[0];
        w_push[1]     = !flush && req1_valid && w_ready[1];
        w_head_addr   = w_grant1 ? r_q_addr[1][0] : r_q_addr[0][0];
        w_head_data   = w_grant1 ? r_q_data[1][0] : r_q_data[0][0];
    end

    // Per-queue FIFO update; a push into a popping queue lands behind the survivor.
    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            for (int k = 0; k < 2; k++) begin
                r_count[k] <= 2'd0;
                for (int e = 0; e < 2; e++) begin
                    r_q_addr[k][e] <= 4'd0;
                    r_q_data[k][e] <= {W{1'b0}};
                end
            end
        end else if (flush) begin
            r_count[0] <= 2'd0;
            r_count[1] <= 2'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                case ({w_push[k], w_pop[k]})
                    2'b10: begin
                        r_q_addr[k][r_count[k][0]] <= w_in_addr[k];
                        r_q_data[k][r_count[k][0]] <= w_in_data[k];
                        r_count[k] <= r_count[k] + 2'd1;
                    end
                    2'b01: begin
                        r_q_addr[k][0] <= r_q_addr[k][1];
                        r_q_data[k][0] <= r_q_data[k][1];
                        r_count[k] <= r_count[k] - 2'd1;
                    end
                    2'b11: begin
                        if (r_count[k] == 2'd1) begin
                            r_q_addr[k][0] <= w_in_addr[k];
                            r_q_data[k][0] <= w_in_data[k];
                        end else begin
                            r_q_addr[k][0] <= r_q_addr[k][1];
                            r_q_data[k][0] <= r_q_data[k][1];
                            r_q_addr[k][1] <= w_in_addr[k];
                            r_q_data[k][1] <= w_in_data[k];
                        end
                    end
                    default: begin
                        r_count[k] <= r_count[k];
                    end
                endcase
            end
        end
    end

    // Grant bookkeeping and the registered write port.
    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            r_ptr      <= 1'b0;
            r_conflict <= 8'd0;
            r_we       <= 1'b0;
            r_waddr    <= 4'd0;
            r_wdata    <= {W{1'b0}};
        end else if (flush) begin
            r_we <= 1'b0;
        end else begin
            if ((&w_nonempty) && (r_conflict != 8'hFF)) begin
                r_conflict <= r_conflict + 8'd1;
            end
            if (|w_pop) begin
                r_waddr <= w_head_addr;
                r_wdata <= w_head_data;
                r_we    <= !(ZERO_REG_DISCARD && (w_head_addr == 4'd0));
                r_ptr   <= !w_grant1;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    // Hazard mask over every live queue entry plus the write in flight.
    always_comb begin
        w_mask = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            w_mask = w_mask | ((r_count[k] != 2'd0) ? (16'h0001 << r_q_addr[k][0]) : 16'h0000);
            w_mask = w_mask | ((r_count[k] == 2'd2) ? (16'h0001 << r_q_addr[k][1]) : 16'h0000);
        end
        w_mask = w_mask | (r_we ? (16'h0001 << r_waddr) : 16'h0000);
    end

    assign req0_ready     = w_ready[0];
    assign req1_ready     = w_ready[1];
    assign write_enable   = r_we;
    assign write_address  = r_waddr;
    assign write_data     = r_wdata;
    assign pending_mask   = w_mask;
    assign conflict_count = r_conflict;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus hand sequences
// for zero-register discard and asynchronous reset mid-stream.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fl = 1'b0;
    logic        v0 = 1'b0;
    logic        v1 = 1'b0;
    logic [3:0]  a0 = 4'd0;
    logic [3:0]  a1 = 4'd0;
    logic [15:0] d0 = 16'h0000;
    logic [15:0] d1 = 16'h0000;

    logic        r0, r1, we;
    logic [3:0]  wa;
    logic [15:0] wd, mask;
    logic [7:0]  cc;
    logic        zr0, zr1, zwe;
    logic [3:0]  zwa;
    logic [15:0] zwd, zmask;
    logic [7:0]  zcc;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.W(16), .ZERO_REG_DISCARD(1'b0)) dut (
        .clk(clk), .reset_asynchronous(rst), .flush(fl),
        .req0_valid(v0), .req0_ready(r0), .req0_address(a0), .req0_data(d0),
        .req1_valid(v1), .req1_ready(r1), .req1_address(a1), .req1_data(d1),
        .write_enable(we), .write_address(wa), .write_data(wd),
        .pending_mask(mask), .conflict_count(cc)
    );

    regfile_write_arbiter #(.W(16), .ZERO_REG_DISCARD(1'b1)) dut_z (
        .clk(clk), .reset_asynchronous(rst), .flush(fl),
        .req0_valid(v0), .req0_ready(zr0), .req0_address(a0), .req0_data(d0),
        .req1_valid(v1), .req1_ready(zr1), .req1_address(a1), .req1_data(d1),
        .write_enable(zwe), .write_address(zwa), .write_data(zwd),
        .pending_mask(zmask), .conflict_count(zcc)
    );

    typedef struct {
        logic        rb;
        logic        fl;
        logic        v0;
        logic [3:0]  a0;
        logic [15:0] d0;
        logic        v1;
        logic [3:0]  a1;
        logic [15:0] d1;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic        r0;
        logic        r1;
        logic [15:0] mask;
        logic [7:0]  cc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rb, f, iv0, input logic [3:0] ia0, input logic [15:0] id0,
                                input logic iv1, input logic [3:0] ia1, input logic [15:0] id1,
                                input logic ewe, input logic [3:0] ewa, input logic [15:0] ewd,
                                input logic er0, er1, input logic [15:0] em, input logic [7:0] ecc);
        vec_t v;
        v.rb = rb; v.fl = f; v.v0 = iv0; v.a0 = ia0; v.d0 = id0; v.v1 = iv1; v.a1 = ia1; v.d1 = id1;
        v.we = ewe; v.wa = ewa; v.wd = ewd; v.r0 = er0; v.r1 = er1; v.mask = em; v.cc = ecc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive(input logic f, iv0, input logic [3:0] ia0, input logic [15:0] id0,
                         input logic iv1, input logic [3:0] ia1, input logic [15:0] id1);
        fl = f; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single write
        vecs.push_back(mk(1,0, 1,4'd5,16'h1234, 0,4'd0,16'h0000, 0,4'd0,16'h0000, 1,1,16'h0020,8'd0));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000, 1,4'd5,16'h1234, 1,1,16'h0020,8'd0));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000, 0,4'd5,16'h1234, 1,1,16'h0000,8'd0));
        // Contention with backpressure: requesters hold their write until accepted
        vecs.push_back(mk(1,0, 1,4'd1,16'hA001, 1,4'd9,16'hB009,  0,4'd0,16'h0000,  1,1,16'h0202,8'd0));
        vecs.push_back(mk(0,0, 1,4'd2,16'hA002, 1,4'd10,16'hB00A, 1,4'd1,16'hA001,  1,0,16'h0606,8'd1));
        vecs.push_back(mk(0,0, 1,4'd3,16'hA003, 1,4'd11,16'hB00B, 1,4'd9,16'hB009,  0,1,16'h060C,8'd2));
        vecs.push_back(mk(0,0, 1,4'd4,16'hA004, 1,4'd11,16'hB00B, 1,4'd2,16'hA002,  1,0,16'h0C0C,8'd3));
        vecs.push_back(mk(0,0, 1,4'd4,16'hA004, 1,4'd12,16'hB00C, 1,4'd10,16'hB00A, 0,1,16'h0C18,8'd4));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 1,4'd12,16'hB00C, 1,4'd3,16'hA003,  1,0,16'h1818,8'd5));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  1,4'd11,16'hB00B, 1,1,16'h1810,8'd6));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  1,4'd4,16'hA004,  1,1,16'h1010,8'd7));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  1,4'd12,16'hB00C, 1,1,16'h1000,8'd7));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  0,4'd12,16'hB00C, 1,1,16'h0000,8'd7));
        // Flush with three writes queued; pointer and conflict count survive it
        vecs.push_back(mk(1,0, 1,4'd1,16'hA001, 1,4'd9,16'hB009,  0,4'd0,16'h0000,  1,1,16'h0202,8'd0));
        vecs.push_back(mk(0,0, 1,4'd2,16'hA002, 1,4'd10,16'hB00A, 1,4'd1,16'hA001,  1,0,16'h0606,8'd1));
        vecs.push_back(mk(0,0, 1,4'd3,16'hA003, 1,4'd11,16'hB00B, 1,4'd9,16'hB009,  0,1,16'h060C,8'd2));
        vecs.push_back(mk(0,1, 1,4'd4,16'hA004, 1,4'd11,16'hB00B, 0,4'd9,16'hB009,  1,1,16'h0000,8'd2));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  0,4'd9,16'hB009,  1,1,16'h0000,8'd2));
        vecs.push_back(mk(0,0, 1,4'd5,16'hA005, 1,4'd13,16'hB00D, 0,4'd9,16'hB009,  1,1,16'h2020,8'd2));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  1,4'd5,16'hA005,  1,1,16'h2020,8'd3));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  1,4'd13,16'hB00D, 1,1,16'h2000,8'd3));
        vecs.push_back(mk(0,0, 0,4'd0,16'h0000, 0,4'd0,16'h0000,  0,4'd13,16'hB00D, 1,1,16'h0000,8'd3));

        // Reset state
        #1;
        check("rst we", {31'd0, we}, 32'd0);
        check("rst addr", {28'd0, wa}, 32'd0);
        check("rst data", {16'd0, wd}, 32'd0);
        check("rst mask", {16'd0, mask}, 32'd0);
        check("rst cc", {24'd0, cc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst rdy0", {31'd0, r0}, 32'd1);
        check("rst rdy1", {31'd0, r1}, 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].rb) do_reset();
            drive(vecs[i].fl, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            step();
            check($sformatf("v%0d we", i),   {31'd0, we},   {31'd0, vecs[i].we});
            check($sformatf("v%0d addr", i), {28'd0, wa},   {28'd0, vecs[i].wa});
            check($sformatf("v%0d data", i), {16'd0, wd},   {16'd0, vecs[i].wd});
            check($sformatf("v%0d rdy0", i), {31'd0, r0},   {31'd0, vecs[i].r0});
            check($sformatf("v%0d rdy1", i), {31'd0, r1},   {31'd0, vecs[i].r1});
            check($sformatf("v%0d mask", i), {16'd0, mask}, {16'd0, vecs[i].mask});
            check($sformatf("v%0d cc", i),   {24'd0, cc},   {24'd0, vecs[i].cc});
        end

        // Zero-register write: discarded on the ZERO_REG_DISCARD instance only
        do_reset();
        drive(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0, 16'h0000);
        step();
        check("z0 mask", {16'd0, zmask}, 32'h0001);
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        step();
        check("z1 we", {31'd0, zwe}, 32'd0);
        check("z1 addr", {28'd0, zwa}, 32'd0);
        check("z1 data", {16'd0, zwd}, 32'h0000FFFF);
        check("z1 mask", {16'd0, zmask}, 32'd0);
        check("z1 rdy0", {31'd0, zr0}, 32'd1);
        check("n1 we", {31'd0, we}, 32'd1);
        check("n1 addr", {28'd0, wa}, 32'd0);
        check("n1 data", {16'd0, wd}, 32'h0000FFFF);
        check("n1 mask", {16'd0, mask}, 32'h0001);

        // Asynchronous reset with three writes queued
        do_reset();
        drive(1'b0, 1'b1, 4'd1, 16'hA001, 1'b1, 4'd9, 16'hB009);
        step();
        drive(1'b0, 1'b1, 4'd2, 16'hA002, 1'b1, 4'd10, 16'hB00A);
        step();
        check("ar pre we", {31'd0, we}, 32'd1);
        check("ar pre cc", {24'd0, cc}, 32'd1);
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        #2;
        rst = 1'b1;
        #1;
        check("ar we", {31'd0, we}, 32'd0);
        check("ar addr", {28'd0, wa}, 32'd0);
        check("ar data", {16'd0, wd}, 32'd0);
        check("ar mask", {16'd0, mask}, 32'd0);
        check("ar cc", {24'd0, cc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 4'd3, 16'hA003, 1'b1, 4'd11, 16'hB00B);
        step();
        drive(1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
        check("ar2 we", {31'd0, we}, 32'd0);
        check("ar2 mask", {16'd0, mask}, 32'h0808);
        check("ar2 cc", {24'd0, cc}, 32'd0);
        step();
        check("ar3 we", {31'd0, we}, 32'd1);
        check("ar3 addr", {28'd0, wa}, 32'd3);
        check("ar3 data", {16'd0, wd}, 32'h0000A003);
        check("ar3 cc", {24'd0, cc}, 32'd1);
        step();
        check("ar4 addr", {28'd0, wa}, 32'd11);
        check("ar4 data", {16'd0, wd}, 32'h0000B00B);
        step();
        check("ar5 we", {31'd0, we}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
